// File: rtl/led_blink_core_if.sv
// led_blink_core_if: synchronous register write/read port between the MMIO bridge and the blink core.
interface led_blink_core_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_data;
  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/led_blink_core.sv
// led_blink_core: per-channel tick counters that toggle each LED at a programmable half-period.
module led_blink_core #(
  parameter int N_LEDS = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  led_blink_core_if.slave   bus,
  output logic [N_LEDS-1:0] led
);
  logic [CNT_W-1:0]  period [N_LEDS];
  logic [CNT_W-1:0]  cnt    [N_LEDS];
  logic [N_LEDS-1:0] enable;
  logic [N_LEDS-1:0] pw;
  logic [N_LEDS-1:0] live;
  logic [CNT_W-1:0]  rd_next;
  logic              en_wr;
  assign en_wr = bus.wr_en && bus.wr_addr == ADDR_W'(N_LEDS);
  // live uses the post-write enable/period so a disable or zero period clears led at the write edge
  always_comb begin
    rd_next = bus.rd_addr == ADDR_W'(N_LEDS) ? CNT_W'(enable) : '0;
    for (int i = 0; i < N_LEDS; i++) begin
      pw[i]   = bus.wr_en && bus.wr_addr == ADDR_W'(i);
      live[i] = (en_wr ? bus.wr_data[i] : enable[i]) && (pw[i] ? bus.wr_data != '0 : period[i] != '0);
      if (bus.rd_addr == ADDR_W'(i)) rd_next = period[i];
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      enable      <= '0;
      led         <= '0;
      bus.rd_data <= '0;
      for (int i = 0; i < N_LEDS; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      bus.rd_data <= rd_next;
      if (en_wr) enable <= bus.wr_data[N_LEDS-1:0];
      for (int i = 0; i < N_LEDS; i++) begin
        if (pw[i]) period[i] <= bus.wr_data;
        if (!live[i]) begin
          cnt[i] <= '0;
          led[i] <= 1'b0;
        end else if (pw[i] || en_wr) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == period[i] - CNT_W'(1)) begin
            cnt[i] <= '0;
            led[i] <= ~led[i];
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
endmodule

// File: tb/tb_led_blink_core.sv
// tb_led_blink_core: vector table plus hand sequences for collision, disable, async reset and max period.
module tb_led_blink_core;
  localparam int OP_W = 0, OP_T = 1, OP_R = 2;
  typedef struct {
    int          op;
    logic [4:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, tick2 = 1'b0;
  logic [3:0] led, led2;
  int checks = 0, failures = 0;
  logic [31:0] exp_q [$];
  vec_t vt [$];
  led_blink_core_if #(.ADDR_W(5), .CNT_W(16)) bus ();
  led_blink_core_if #(.ADDR_W(5), .CNT_W(8))  bus2 ();
  led_blink_core #(.N_LEDS(4), .CNT_W(16), .ADDR_W(5)) dut  (.clk(clk), .rst(rst), .tick(tick),  .bus(bus),  .led(led));
  led_blink_core #(.N_LEDS(4), .CNT_W(8),  .ADDR_W(5)) dut2 (.clk(clk), .rst(rst), .tick(tick2), .bus(bus2), .led(led2));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask
  task automatic wr2(input logic [4:0] a, input logic [7:0] d);
    bus2.wr_en = 1'b1; bus2.wr_addr = a; bus2.wr_data = d;
    @(negedge clk);
    bus2.wr_en = 1'b0;
  endtask
  task automatic pulse();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask
  task automatic pulse2();
    tick2 = 1'b1;
    @(negedge clk);
    tick2 = 1'b0;
    @(negedge clk);
  endtask
  task automatic rd(input string name, input logic [4:0] a, input logic [15:0] exp);
    bus.rd_addr = a;
    exp_q.push_back(32'(exp));
    @(negedge clk);
    chk(name, 32'(bus.rd_data), exp_q.pop_front());
  endtask
  function automatic void add(input int op, input logic [4:0] a, input logic [15:0] d, input logic [15:0] e);
    vt.push_back('{op, a, d, e});
  endfunction

  initial begin
    logic early;
    bus.wr_en = 1'b0;  bus.wr_addr = '0;  bus.wr_data = '0;  bus.rd_addr = '0;
    bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_rd", 32'(bus.rd_data), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    add(OP_W, 0, 3, 0); add(OP_W, 4, 1, 0);
    add(OP_T, 0, 0, 0); add(OP_T, 0, 0, 0); add(OP_T, 0, 0, 1);
    add(OP_T, 0, 0, 1); add(OP_T, 0, 0, 1); add(OP_T, 0, 0, 0);
    add(OP_T, 0, 0, 0); add(OP_T, 0, 0, 0); add(OP_T, 0, 0, 1);
    add(OP_W, 1, 1, 1); add(OP_W, 4, 3, 1);
    add(OP_T, 0, 0, 3); add(OP_T, 0, 0, 1); add(OP_T, 0, 0, 2); add(OP_T, 0, 0, 0);
    add(OP_R, 0, 0, 3); add(OP_R, 1, 0, 1); add(OP_R, 4, 0, 3); add(OP_R, 9, 0, 0); add(OP_R, 2, 0, 0);
    add(OP_W, 2, 16'hFFFF, 0); add(OP_R, 2, 0, 16'hFFFF);
    add(OP_W, 4, 16'hFFFF, 0); add(OP_R, 4, 0, 16'h000F);
    add(OP_T, 0, 0, 2); add(OP_T, 0, 0, 0); add(OP_T, 0, 0, 3);
    foreach (vt[k]) begin
      if (vt[k].op == OP_W) begin
        wr(vt[k].addr, vt[k].data);
        chk($sformatf("vec%0d_wr_led", k), 32'(led), 32'(vt[k].exp));
      end else if (vt[k].op == OP_T) begin
        pulse();
        chk($sformatf("vec%0d_tick_led", k), 32'(led), 32'(vt[k].exp));
      end else begin
        rd($sformatf("vec%0d_rd", k), vt[k].addr, vt[k].exp);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wr(0, 2); wr(4, 1);
    pulse();
    chk("coll_pre_led", 32'(led), 32'h0);
    tick = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 0; bus.wr_data = 5; bus.rd_addr = 0;
    exp_q.push_back(32'h2);
    @(negedge clk);
    tick = 1'b0; bus.wr_en = 1'b0;
    chk("coll_rd_old", 32'(bus.rd_data), exp_q.pop_front());
    chk("coll_no_toggle", 32'(led), 32'h0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      pulse();
      chk($sformatf("coll_wait%0d", i), 32'(led), 32'h0);
    end
    pulse();
    chk("coll_toggle", 32'(led), 32'h1);
    wr(4, 0);
    chk("dis_led", 32'(led), 32'h0);
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse();
      if (led !== 4'h0) early = 1'b1;
    end
    chk("dis_ignore_ticks", 32'(early), 32'h0);
    wr(4, 1);
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse();
      if (led !== 4'h0) early = 1'b1;
    end
    chk("reen_no_early", 32'(early), 32'h0);
    pulse();
    chk("reen_toggle", 32'(led), 32'h1);
    wr(0, 0);
    chk("zero_led", 32'(led), 32'h0);
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse();
      if (led !== 4'h0) early = 1'b1;
    end
    chk("zero_stays", 32'(early), 32'h0);
    wr(1, 1); wr(3, 1); wr(4, 16'hA);
    pulse();
    chk("pre_rst_led", 32'(led), 32'hA);
    rd("pre_rst_rd", 1, 1);
    #2 rst = 1'b0;
    #1 chk("async_rst_led", 32'(led), 32'h0);
    chk("async_rst_rd", 32'(bus.rd_data), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) rd($sformatf("post_rst_period%0d", i), 5'(i), 0);
    wr2(2, 8'hFF); wr2(4, 8'h04);
    early = 1'b0;
    for (int i = 0; i < 254; i++) begin
      pulse2();
      if (led2 !== 4'h0) early = 1'b1;
    end
    chk("max_no_early", 32'(early), 32'h0);
    pulse2();
    chk("max_toggle", 32'(led2), 32'h4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_blink_core.md
Name: led_blink_core

Overview:
- Multi-channel LED blink generator directly downstream of the refresh-rate divider.
- Consumes the divider's one-cycle tick strobe, counts ticks per channel and toggles each LED output at a software-programmed half-period.
- Exposes a small synchronous register interface so the softcore's MMIO bridge can set periods and enables.

Parameters:
- N_LEDS, 4, number of independent blink channels (1..16).
- CNT_W, 16, width of each period register and tick counter.
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W > N_LEDS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- tick  in  1  one-cycle strobe from the refresh-rate divider (e.g. 1 kHz); never asserted two consecutive cycles
- wr_en  in  1  register write strobe, one cycle
- wr_addr  in  ADDR_W  write address
- wr_data  in  CNT_W  write data
- rd_addr  in  ADDR_W  read address
- rd_data  out  CNT_W  registered read data
- led  out  N_LEDS  blink outputs, bit i = channel i

Behaviour:
- Register map:
  - addr i (0..N_LEDS-1) = PERIOD[i], half-period in ticks.
  - addr N_LEDS = ENABLE, bits [N_LEDS-1:0] used, upper bits ignored on write and read as 0.
  - Other addresses: writes ignored, reads return 0.
- Reset (rst low, asynchronous): PERIOD[*]=0, ENABLE=0, all counters=0, led=0, rd_data=0. Deassertion is used as-is; the reset synchroniser is upstream.
- Per-channel counter cnt[i], CNT_W bits. On a cycle with tick=1, ENABLE[i]=1 and PERIOD[i]!=0:
  - If cnt[i]==PERIOD[i]-1: cnt[i]<=0 and led[i]<=~led[i].
  - Else: cnt[i]<=cnt[i]+1.
- Result: led[i] toggles every PERIOD[i] ticks. Full blink period = 2*PERIOD[i] ticks.
- PERIOD[i]==1: led[i] toggles on every tick.
- PERIOD[i]==0 or ENABLE[i]==0: cnt[i] held at 0, led[i] forced 0 on the next clock edge, and ticks are ignored.
- Max period 2^CNT_W-1. The counter never wraps past PERIOD-1, and the compare is done at full CNT_W width.
- Writes take effect at the clock edge where wr_en=1:
  - Write to PERIOD[i]: cnt[i]<=0. led[i] keeps its current value. Counting restarts from 0 with the new period on the next tick.
  - Write to ENABLE: a channel going 0->1 starts with cnt=0 and led=0. Its first toggle comes after PERIOD ticks.
- Simultaneous tick and write to the same channel's PERIOD or ENABLE: the write wins. The counter clears and no toggle occurs on that edge. Other channels process the tick normally.
- Read latency is 1 cycle: rd_data is the register at rd_addr as sampled on the previous edge. Read of an address written in the same cycle returns the old value.
- led is registered directly; no combinational path from any input to led.

Test Plan:
- Reset: drive rst=0 mid-operation with led=4'b1010 -> led=0 and rd_data=0 immediately, with no clock edge needed; all PERIOD regs read back 0 after release.
- Basic blink: write PERIOD[0]=3, ENABLE=4'b0001, issue a tick every 10 clk -> led[0] toggles on the 3rd, 6th and 9th tick; led[3:1] stay 0.
- Period 1 and max: PERIOD[1]=1 toggles on every tick. PERIOD[2]=16'hFFFF, after 65534 ticks -> led[2] still 0; the 65535th tick -> led[2]=1.
- Collision: PERIOD[0]=2 with cnt[0]=1, assert tick and wr_en (addr 0, data 5) on the same edge -> no toggle and cnt cleared; next toggle after 5 further ticks.
- Disable/zero: with led[0]=1, write ENABLE=0 -> led[0]=0 the next cycle and ticks are ignored. Re-enable -> first toggle after PERIOD ticks. PERIOD=0 with enabled -> led stays 0.
- Readback: write ENABLE=16'hFFFF (N_LEDS=4) -> read addr 4 gives 16'h000F one cycle later; read addr 9 -> 0.
